// File: rtl/plb_port_arbiter_if.sv
// rtl/plb_port_arbiter_if.sv - requester-side and PLB-side bus bundle for plb_port_arbiter
interface plb_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic [NUM_REQ-1:0]              s_mem_req;
  logic [NUM_REQ-1:0]              s_mem_gnt;
  logic [NUM_REQ-1:0]              s_mem_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_mem_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]   s_mem_wdata;
  logic [NUM_REQ-1:0]              s_mem_we;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_mem_be;
  logic [DATA_WIDTH-1:0]           s_mem_rdata;
  logic [NUM_REQ-1:0]              s_mem_error;

  logic                            m_mem_req;
  logic [ADDR_WIDTH-1:0]           m_mem_addr;
  logic [DATA_WIDTH-1:0]           m_mem_wdata;
  logic                            m_mem_we;
  logic [DATA_WIDTH/8-1:0]         m_mem_be;
  logic                            m_mem_gnt;
  logic                            m_mem_valid;
  logic                            m_mem_error;
  logic [DATA_WIDTH-1:0]           m_mem_rdata;

  // Arbiter view: answers the requesters and drives the PLB request.
  modport slave (
    input  s_mem_req, s_mem_addr, s_mem_wdata, s_mem_we, s_mem_be,
    input  m_mem_gnt, m_mem_valid, m_mem_error, m_mem_rdata,
    output s_mem_gnt, s_mem_valid, s_mem_rdata, s_mem_error,
    output m_mem_req, m_mem_addr, m_mem_wdata, m_mem_we, m_mem_be
  );

  // Environment view: requesters plus the PLB cache.
  modport master (
    output s_mem_req, s_mem_addr, s_mem_wdata, s_mem_we, s_mem_be,
    output m_mem_gnt, m_mem_valid, m_mem_error, m_mem_rdata,
    input  s_mem_gnt, s_mem_valid, s_mem_rdata, s_mem_error,
    input  m_mem_req, m_mem_addr, m_mem_wdata, m_mem_we, m_mem_be
  );
endinterface

// File: rtl/plb_port_arbiter.sv
// rtl/plb_port_arbiter.sv - round-robin PLB port arbiter with grant lock and in-order response steering
module plb_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  plb_port_arbiter_if.slave                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               spurious_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       lock_sel_q, lock_sel_d;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                spurious_q;

  logic [NUM_REQ-1:0]  eligible;
  logic                can_issue;
  logic                any_elig;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       sel_rr;
  logic [IW-1:0]       sel;
  logic                m_req;
  logic                push;
  logic                pop;
  logic [IW-1:0]       head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (MAX_OUTSTANDING == 1) ? '0 : p + 1'b1;
  endfunction

  assign can_issue = (count_q < CW'(MAX_OUTSTANDING));
  assign eligible  = can_issue ? bus.s_mem_req : '0;

  // Descending scan so the last hit is the first eligible index at or after rr_ptr.
  always_comb begin
    sel_rr   = rr_ptr_q;
    any_elig = 1'b0;
    idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (eligible[idx]) begin
        sel_rr   = idx;
        any_elig = 1'b1;
      end
    end
  end

  assign sel   = (state_q == LOCKED) ? lock_sel_q : sel_rr;
  // Reset gates the combinational request so the port is quiet while rst_i is held.
  assign m_req = ~rst_i & ((state_q == LOCKED) ? eligible[lock_sel_q] : any_elig);
  assign push  = m_req & bus.m_mem_gnt;
  assign pop   = ~rst_i & bus.m_mem_valid & (count_q != '0);
  assign head  = fifo_q[rd_ptr_q];

  assign bus.m_mem_req   = m_req;
  assign bus.m_mem_addr  = bus.s_mem_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.m_mem_wdata = bus.s_mem_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_mem_we    = bus.s_mem_we[sel];
  assign bus.m_mem_be    = bus.s_mem_be[int'(sel)*BW +: BW];

  assign bus.s_mem_gnt   = push ? (NUM_REQ'(1) << sel) : '0;
  assign bus.s_mem_valid = pop ? (NUM_REQ'(1) << head) : '0;
  assign bus.s_mem_error = (pop & bus.m_mem_error) ? (NUM_REQ'(1) << head) : '0;
  assign bus.s_mem_rdata = bus.m_mem_rdata;

  assign outstanding_o = count_q;
  assign spurious_o    = spurious_q;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE: begin
        if (m_req && !bus.m_mem_gnt) begin
          state_d    = LOCKED;
          lock_sel_d = sel;
        end
      end
      LOCKED: begin
        // A requester withdrawing while locked is tolerated: release without a grant.
        if (!bus.s_mem_req[lock_sel_q] || bus.m_mem_gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr_q <= IW'((int'(sel) + 1) % NUM_REQ);
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (bus.m_mem_valid && (count_q == '0)) begin
        spurious_q <= 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // ID storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end
endmodule

// File: tb/tb_plb_port_arbiter.sv
// tb/tb_plb_port_arbiter.sv - directed vector table, reset sequences and randomized model check for plb_port_arbiter
module tb_plb_port_arbiter;
  localparam int NR = 2;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] outstanding;
  logic          spurious;

  plb_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  plb_port_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .outstanding_o(outstanding),
    .spurious_o(spurious)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       vld;
    logic       err;
    logic       mreq;
    int         ak;
    logic [1:0] sgnt;
    logic [1:0] svld;
    logic [1:0] serr;
    int         cnt;
    logic       spur;
  } vec_t;

  vec_t tbl[$];

  logic [AW-1:0] ra  [NR];
  logic [DW-1:0] rw  [NR];
  logic          rwe [NR];
  logic [BW-1:0] rbe [NR];
  logic [DW-1:0] rdat;

  int m_q[$];
  int m_rr;
  bit m_locked;
  int m_lock;
  bit m_spur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic [1:0] req, input logic gnt, input logic vld,
                               input logic err, input logic mreq, input int ak,
                               input logic [1:0] sgnt, input logic [1:0] svld,
                               input logic [1:0] serr, input int cnt, input logic spur);
    vec_t v;
    v.req = req; v.gnt = gnt; v.vld = vld; v.err = err; v.mreq = mreq; v.ak = ak;
    v.sgnt = sgnt; v.svld = svld; v.serr = serr; v.cnt = cnt; v.spur = spur;
    return v;
  endfunction

  task automatic pack_req();
    for (int k = 0; k < NR; k++) begin
      bus.s_mem_addr[k*AW +: AW]  = ra[k];
      bus.s_mem_wdata[k*DW +: DW] = rw[k];
      bus.s_mem_we[k]             = rwe[k];
      bus.s_mem_be[k*BW +: BW]    = rbe[k];
    end
  endtask

  task automatic set_fixed();
    for (int k = 0; k < NR; k++) begin
      ra[k]  = 64'h1000 * (k + 1);
      rw[k]  = 64'hA0 + 64'(k);
      rwe[k] = (k == 1);
      rbe[k] = 8'hF0 >> k;
    end
    pack_req();
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic vld, input logic err);
    bus.s_mem_req   = req;
    bus.m_mem_gnt   = gnt;
    bus.m_mem_valid = vld;
    bus.m_mem_error = err;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.req, v.gnt, v.vld, v.err);
    rdat = {$urandom, $urandom};
    bus.m_mem_rdata = rdat;
    #1;
    chk({tag, ".m_mem_req"},   64'(bus.m_mem_req),   64'(v.mreq));
    chk({tag, ".s_mem_gnt"},   64'(bus.s_mem_gnt),   64'(v.sgnt));
    chk({tag, ".s_mem_valid"}, 64'(bus.s_mem_valid), 64'(v.svld));
    chk({tag, ".s_mem_error"}, 64'(bus.s_mem_error), 64'(v.serr));
    chk({tag, ".outstanding"}, 64'(outstanding),     64'(v.cnt));
    chk({tag, ".spurious"},    64'(spurious),        64'(v.spur));
    if (v.mreq) begin
      chk({tag, ".m_mem_addr"}, bus.m_mem_addr, 64'h1000 * (v.ak + 1));
      chk({tag, ".m_mem_we"},   64'(bus.m_mem_we), 64'(v.ak == 1));
    end
    if (v.svld != 2'b00) chk({tag, ".s_mem_rdata"}, bus.s_mem_rdata, rdat);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr = 0;
    m_locked = 0;
    m_lock = 0;
    m_spur = 0;
  endtask

  task automatic model_cycle(input int c);
    int sel;
    int k;
    logic [NR-1:0] e_gnt, e_vld, e_err;
    bit do_pop;
    string tag;
    tag = $sformatf("rnd%0d", c);
    sel = -1;
    if (m_locked) begin
      if (bus.s_mem_req[m_lock] && m_q.size() < MO) sel = m_lock;
    end else if (m_q.size() < MO) begin
      for (int i = 0; i < NR; i++) begin
        k = (m_rr + i) % NR;
        if (sel < 0 && bus.s_mem_req[k]) sel = k;
      end
    end
    do_pop = bus.m_mem_valid && (m_q.size() > 0);
    e_gnt = (sel >= 0 && bus.m_mem_gnt) ? NR'(1) << sel : '0;
    e_vld = do_pop ? NR'(1) << m_q[0] : '0;
    e_err = (do_pop && bus.m_mem_error) ? NR'(1) << m_q[0] : '0;

    chk({tag, ".m_mem_req"},   64'(bus.m_mem_req),   64'(sel >= 0));
    chk({tag, ".s_mem_gnt"},   64'(bus.s_mem_gnt),   64'(e_gnt));
    chk({tag, ".s_mem_valid"}, 64'(bus.s_mem_valid), 64'(e_vld));
    chk({tag, ".s_mem_error"}, 64'(bus.s_mem_error), 64'(e_err));
    chk({tag, ".outstanding"}, 64'(outstanding),     64'(m_q.size()));
    chk({tag, ".spurious"},    64'(spurious),        64'(m_spur));
    chk({tag, ".s_mem_rdata"}, bus.s_mem_rdata,      rdat);
    if (sel >= 0) begin
      chk({tag, ".m_mem_addr"},  bus.m_mem_addr,      ra[sel]);
      chk({tag, ".m_mem_wdata"}, bus.m_mem_wdata,     rw[sel]);
      chk({tag, ".m_mem_we"},    64'(bus.m_mem_we),   64'(rwe[sel]));
      chk({tag, ".m_mem_be"},    64'(bus.m_mem_be),   64'(rbe[sel]));
    end

    if (bus.m_mem_valid && m_q.size() == 0) m_spur = 1;
    if (do_pop) void'(m_q.pop_front());
    if (sel >= 0 && bus.m_mem_gnt) begin
      m_q.push_back(sel);
      m_rr = (sel + 1) % NR;
    end
    if (!m_locked) begin
      if (sel >= 0 && !bus.m_mem_gnt) begin
        m_locked = 1;
        m_lock = sel;
      end
    end else if (!bus.s_mem_req[m_lock] || bus.m_mem_gnt) begin
      m_locked = 0;
    end
  endtask

  initial begin
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    bus.m_mem_rdata = '0;
    set_fixed();

    // Reset state, with requests and a response applied while reset is held.
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b1, 1'b0);
    #1;
    chk("rst.m_mem_req",   64'(bus.m_mem_req),   64'd0);
    chk("rst.s_mem_gnt",   64'(bus.s_mem_gnt),   64'd0);
    chk("rst.s_mem_valid", 64'(bus.s_mem_valid), 64'd0);
    chk("rst.s_mem_error", 64'(bus.s_mem_error), 64'd0);
    chk("rst.outstanding", 64'(outstanding),     64'd0);
    chk("rst.spurious",    64'(spurious),        64'd0);
    chk("rst.m_mem_addr",  bus.m_mem_addr,       64'h1000);
    chk("rst.m_mem_wdata", bus.m_mem_wdata,      64'hA0);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    //            req    g  v  e  mreq ak sgnt   svld   serr  cnt spur
    tbl.push_back(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0)); // single requester
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0));
    tbl.push_back(row(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(row(2'b11, 1, 0, 0, 1, 1, 2'b10, 2'b00, 2'b00, 0, 0)); // round robin
    tbl.push_back(row(2'b11, 1, 1, 0, 1, 0, 2'b01, 2'b10, 2'b00, 1, 0));
    tbl.push_back(row(2'b11, 1, 1, 0, 1, 1, 2'b10, 2'b01, 2'b00, 1, 0));
    tbl.push_back(row(2'b11, 1, 1, 0, 1, 0, 2'b01, 2'b10, 2'b00, 1, 0));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0));
    tbl.push_back(row(2'b10, 1, 0, 0, 1, 1, 2'b10, 2'b00, 2'b00, 0, 0)); // move rr_ptr to 0
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0));
    tbl.push_back(row(2'b10, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0)); // lock on requester 1
    tbl.push_back(row(2'b11, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(row(2'b11, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(row(2'b11, 1, 0, 0, 1, 1, 2'b10, 2'b00, 2'b00, 0, 0));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0));
    tbl.push_back(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0)); // fill to MAX_OUTSTANDING
    tbl.push_back(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 1, 0));
    tbl.push_back(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2, 0));
    tbl.push_back(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3, 0));
    tbl.push_back(row(2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4, 0));
    tbl.push_back(row(2'b01, 1, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4, 0));
    tbl.push_back(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3, 0));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4, 0));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3, 0));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2, 0));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0));
    tbl.push_back(row(2'b10, 1, 0, 0, 1, 1, 2'b10, 2'b00, 2'b00, 0, 0)); // error then spurious
    tbl.push_back(row(2'b00, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 1, 0));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(row(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1));
    tbl.push_back(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0, 1));
    tbl.push_back(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 1));

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Asynchronous reset with two transactions in flight.
    apply_vec(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 0, 1), "ar0");
    apply_vec(row(2'b01, 1, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 1, 1), "ar1");
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ar.pre_outstanding", 64'(outstanding), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.outstanding", 64'(outstanding),     64'd0);
    chk("ar.spurious",    64'(spurious),        64'd0);
    chk("ar.m_mem_req",   64'(bus.m_mem_req),   64'd0);
    chk("ar.s_mem_gnt",   64'(bus.s_mem_gnt),   64'd0);
    chk("ar.m_mem_addr",  bus.m_mem_addr,       64'h1000);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    apply_vec(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "ar_late0");
    apply_vec(row(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1), "ar_late1");
    apply_vec(row(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1), "ar_after");

    // Randomized traffic against the queue-based reference model.
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        ra[k]  = {$urandom, $urandom};
        rw[k]  = {$urandom, $urandom};
        rwe[k] = 1'($urandom_range(0, 1));
        rbe[k] = BW'($urandom);
      end
      pack_req();
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      rdat = {$urandom, $urandom};
      bus.m_mem_rdata = rdat;
      #1;
      model_cycle(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/plb_port_arbiter.md
# plb_port_arbiter

Shares the single PLB SRAM-style memory port between `NUM_REQ` requesters, such as the PLB lookup stage and a PLB refill/invalidate engine. It places no extra pipeline stage in the request path. Arbitration is round-robin with a stable hold while a request waits for its grant. Responses are steered back in order through an ID FIFO that tracks outstanding transactions. The block sits between the MPT walker's PLB-facing stages and the PLB cache.

## Interface
- `NUM_REQ`, default 2: number of requester ports; minimum 1.
- `DATA_WIDTH`, default 64: PLB data width.
- `ADDR_WIDTH`, default 64: PLB address (tag) width.
- `MAX_OUTSTANDING`, default 4: maximum granted-but-unanswered transactions; a power of 2, ≥1.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `s_mem_req`  in  `NUM_REQ`  per-requester request.
- `s_mem_gnt`  out  `NUM_REQ`  per-requester grant.
- `s_mem_valid`  out  `NUM_REQ`  per-requester response valid.
- `s_mem_addr`  in  `NUM_REQ*ADDR_WIDTH`  packed; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `s_mem_wdata`  in  `NUM_REQ*DATA_WIDTH`  packed write data.
- `s_mem_we`  in  `NUM_REQ`  write enable.
- `s_mem_be`  in  `NUM_REQ*DATA_WIDTH/8`  packed byte enables.
- `s_mem_rdata`  out  `DATA_WIDTH`  broadcast read data; qualified by `s_mem_valid`.
- `s_mem_error`  out  `NUM_REQ`  per-requester error, asserted with `s_mem_valid`.
- `m_mem_req`, `m_mem_addr`, `m_mem_wdata`, `m_mem_we`, `m_mem_be`  out  1 / `ADDR_WIDTH` / `DATA_WIDTH` / 1 / `DATA_WIDTH/8`  request to the PLB.
- `m_mem_gnt`, `m_mem_valid`, `m_mem_error`  in  1  PLB grant, response valid, error.
- `m_mem_rdata`  in  `DATA_WIDTH`  PLB read data.
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING)+1`  current outstanding count.
- `spurious_o`  out  1  sticky flag: a response arrived with nothing outstanding.

## Operation
- **Eligibility:**
  - Requester k is eligible when `s_mem_req[k]` is high and `count < MAX_OUTSTANDING`.
  - At `count == MAX_OUTSTANDING`, `m_mem_req = 0` and all `s_mem_gnt = 0`, even if a response pops in the same cycle.
- **Selection:**
  - The first eligible index at or after `rr_ptr`, searching with wrap-around.
  - `m_mem_*` request fields are muxed from the selected requester.
  - `m_mem_req` is high when any requester is eligible.
  - `s_mem_gnt[sel] = m_mem_gnt`; every other `s_mem_gnt` bit is 0.
- **Lock state:**
  - States are `IDLE` and `LOCKED`.
  - `IDLE -> LOCKED` when `m_mem_req && !m_mem_gnt`; the registered `lock_sel` captures `sel`.
  - In `LOCKED`, the selection is forced to `lock_sel` regardless of other requesters.
  - `LOCKED -> IDLE` on `m_mem_gnt`.
  - `LOCKED -> IDLE` also if `s_mem_req[lock_sel]` drops. This is a protocol violation by the requester; it is tolerated and no grant is issued.
- **Handshake** (`m_mem_req && m_mem_gnt`):
  - Push `sel` into the ID FIFO (depth `MAX_OUTSTANDING`).
  - `rr_ptr <= (sel + 1) mod NUM_REQ`.
- **Response** (`m_mem_valid`):
  - If the FIFO is non-empty, `head = FIFO[rd_ptr]`.
  - `s_mem_valid[head] = 1`, `s_mem_error[head] = m_mem_error`, then pop.
  - `s_mem_rdata = m_mem_rdata` at all times.
- **Empty-FIFO response:** if the FIFO is empty, the response is dropped, no `s_mem_valid` is raised, and `spurious_o <= 1`.
- **Count update:** push and pop in the same cycle leave `count` unchanged. Read and write pointers wrap modulo `MAX_OUTSTANDING`.
- **Reset values:**
  - `rr_ptr = 0`, `count = 0`, FIFO pointers = 0, state `IDLE`, `spurious_o = 0`.
  - All `s_mem_gnt`, `s_mem_valid`, `s_mem_error` = 0; `m_mem_req = 0`.
  - `m_mem_*` data fields follow requester 0's inputs.
- **Reset mid-transaction:** in-flight IDs are discarded. Later PLB responses for them set `spurious_o`.

## Timing
- Request path is combinational, zero added latency: `s_mem_req` to `m_mem_req`, and `m_mem_gnt` to `s_mem_gnt`.
- Response path is combinational, zero cycles: `m_mem_valid` to `s_mem_valid[head]`.
- A transaction granted in cycle t may be answered from cycle t+1 onward. Responses are in order.
- Per-cycle ordering:
  - A pop of the old head and a push of a new ID in the same cycle are both legal.
  - The response is routed using the FIFO head before that cycle's push.
- `NUM_REQ == 1`: `rr_ptr` is constant 0, and the block reduces to outstanding tracking.
- Registered state: `rr_ptr`, lock state and `lock_sel`, FIFO contents and pointers, `count`, `spurious_o`.

## Test plan
- **Single requester:** requester 0 reads addr 0x1000; PLB grants at once and returns rdata 0x1 one cycle later. Required: `s_mem_gnt[0]` in cycle 0, `s_mem_valid[0]` with rdata 0x1 in cycle 1, `outstanding_o` 1 then 0.
- **Round-robin fairness:** both requesters hold req high and PLB always grants. Required: grants alternate 0,1,0,1, and responses go to the matching `s_mem_valid` bit in order.
- **Lock hold:** requester 1 is selected, PLB holds `m_mem_gnt = 0` for 3 cycles, and requester 0 raises req meanwhile. Required: `m_mem_addr` stays at requester 1's address and the first grant goes to requester 1.
- **Backpressure:** with `MAX_OUTSTANDING = 4`, 4 grants are issued with no responses. Required: `m_mem_req = 0` while `outstanding_o = 4`. After one response, `m_mem_req` reasserts the next cycle.
- **Error and spurious:** PLB answers with `m_mem_error = 1`; then `m_mem_valid` pulses with the FIFO empty. Required: `s_mem_error[head] = 1` with `s_mem_valid`; then no `s_mem_valid` and `spurious_o = 1` until `rst_i`.
- **Async reset mid-flight:** assert `rst_i` with 2 transactions outstanding. Required: outputs go to their reset values immediately without waiting for a clock edge; the 2 late responses set `spurious_o`.
